// File: rtl/viterbi_metric_core.sv
// Metric datapath of a rate-1/2, 4-state hard-decision Viterbi decoder: BMU, ACS and PMU.
// Optional build macro VITERBI_PM_NORM_EN subtracts the minimum new path metric before registering.
module viterbi_metric_core #(
  parameter int SIZE_DATA = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [1:0]           i_data,
  output logic [1:0]           o_BM_0,
  output logic [1:0]           o_BM_1,
  output logic [1:0]           o_BM_2,
  output logic [1:0]           o_BM_3,
  output logic [SIZE_DATA-1:0] o_PM_0,
  output logic [SIZE_DATA-1:0] o_PM_1,
  output logic [SIZE_DATA-1:0] o_PM_2,
  output logic [SIZE_DATA-1:0] o_PM_3,
  output logic [3:0]           o_dec,
  output logic                 o_valid
);

  localparam logic [SIZE_DATA-1:0] MAX = '1;

  logic [1:0]           bm     [4];
  logic [SIZE_DATA-1:0] pm_q   [4];
  logic [SIZE_DATA-1:0] cand_a [4];
  logic [SIZE_DATA-1:0] cand_b [4];
  logic [SIZE_DATA-1:0] sel_pm [4];
  logic [SIZE_DATA-1:0] new_pm [4];
  logic [3:0]           sel_second;

  // Sum is one bit wider than the metric so overflow is visible before clamping.
  function automatic logic [SIZE_DATA-1:0] sat_add(input logic [1:0] b,
                                                   input logic [SIZE_DATA-1:0] p);
    logic [SIZE_DATA:0] s;
    s = {{(SIZE_DATA-1){1'b0}}, b} + {1'b0, p};
    return s[SIZE_DATA] ? MAX : s[SIZE_DATA-1:0];
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    logic [1:0] diff;
    diff = '0;
    for (int k = 0; k < 4; k++) begin
      diff  = i_data ^ 2'(k);
      bm[k] = {1'b0, diff[1]} + {1'b0, diff[0]};
    end
  end

  assign o_BM_0 = bm[0];
  assign o_BM_1 = bm[1];
  assign o_BM_2 = bm[2];
  assign o_BM_3 = bm[3];

  // Butterfly: states 0/2 are fed from PM_0/PM_1, states 1/3 from PM_2/PM_3.
  always_comb begin
    cand_a[0] = sat_add(bm[0], pm_q[0]);
    cand_b[0] = sat_add(bm[3], pm_q[1]);
    cand_a[1] = sat_add(bm[2], pm_q[2]);
    cand_b[1] = sat_add(bm[1], pm_q[3]);
    cand_a[2] = sat_add(bm[3], pm_q[0]);
    cand_b[2] = sat_add(bm[0], pm_q[1]);
    cand_a[3] = sat_add(bm[1], pm_q[2]);
    cand_b[3] = sat_add(bm[2], pm_q[3]);
  end

  always_comb begin
    sel_second = '0;
    for (int s = 0; s < 4; s++) begin
      sel_second[s] = cand_b[s] < cand_a[s];  // tie keeps the first candidate
      sel_pm[s]     = sel_second[s] ? cand_b[s] : cand_a[s];
    end
  end

`ifdef VITERBI_PM_NORM_EN
  always_comb begin
    logic [SIZE_DATA-1:0] m01, m23, mn;
    m01 = (sel_pm[0] < sel_pm[1]) ? sel_pm[0] : sel_pm[1];
    m23 = (sel_pm[2] < sel_pm[3]) ? sel_pm[2] : sel_pm[3];
    mn  = (m01 < m23) ? m01 : m23;
    for (int s = 0; s < 4; s++) new_pm[s] = sel_pm[s] - mn;
  end
`else
  always_comb begin
    for (int s = 0; s < 4; s++) new_pm[s] = sel_pm[s];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  // The metric bank is reset because decoding must start from a known state (state 0 favoured).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pm_q[0] <= '0;
      pm_q[1] <= MAX;
      pm_q[2] <= MAX;
      pm_q[3] <= MAX;
      o_dec   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        for (int s = 0; s < 4; s++) pm_q[s] <= new_pm[s];
        o_dec <= sel_second;
      end
    end
  end

  assign o_PM_0 = pm_q[0];
  assign o_PM_1 = pm_q[1];
  assign o_PM_2 = pm_q[2];
  assign o_PM_3 = pm_q[3];

endmodule

// File: tb/tb_viterbi_metric_core.sv
// Self-checking bench for viterbi_metric_core: directed vectors, random run against a model, async reset.
module tb_viterbi_metric_core;

  localparam int MAXV = 3;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic [1:0] i_data;
  logic [1:0] o_BM_0, o_BM_1, o_BM_2, o_BM_3;
  logic [1:0] o_PM_0, o_PM_1, o_PM_2, o_PM_3;
  logic [3:0] o_dec;
  logic       o_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state and butterfly predecessor table (state, branch codeword).
  int         m_pm [4];
  logic [3:0] m_dec;
  logic       m_valid;
  int p1 [4] = '{0, 2, 0, 2};
  int c1 [4] = '{0, 2, 3, 1};
  int p2 [4] = '{1, 3, 1, 3};
  int c2 [4] = '{3, 1, 0, 2};

  viterbi_metric_core #(.SIZE_DATA(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_BM_0  (o_BM_0),
    .o_BM_1  (o_BM_1),
    .o_BM_2  (o_BM_2),
    .o_BM_3  (o_BM_3),
    .o_PM_0  (o_PM_0),
    .o_PM_1  (o_PM_1),
    .o_PM_2  (o_PM_2),
    .o_PM_3  (o_PM_3),
    .o_dec   (o_dec),
    .o_valid (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_pm    = '{0, MAXV, MAXV, MAXV};
    m_dec   = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] d);
    int bmv [4];
    int nxt [4];
    int a, b, mn;
    logic [3:0] dn;
    dn = '0;
    for (int k = 0; k < 4; k++) bmv[k] = $countones(d ^ 2'(k));
    for (int s = 0; s < 4; s++) begin
      a = m_pm[p1[s]] + bmv[c1[s]];
      b = m_pm[p2[s]] + bmv[c2[s]];
      if (a > MAXV) a = MAXV;
      if (b > MAXV) b = MAXV;
      if (a <= b) nxt[s] = a;
      else begin
        nxt[s] = b;
        dn[s]  = 1'b1;
      end
    end
`ifdef VITERBI_PM_NORM_EN
    mn = nxt[0];
    for (int s = 1; s < 4; s++) if (nxt[s] < mn) mn = nxt[s];
    for (int s = 0; s < 4; s++) nxt[s] -= mn;
`else
    mn = 0;
`endif
    if (v) begin
      m_pm  = nxt;
      m_dec = dn;
    end
    m_valid = v;
  endtask

  function automatic logic [7:0] model_bm(input logic [1:0] d);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[2*k +: 2] = 2'($countones(d ^ 2'(k)));
    return r;
  endfunction

  function automatic logic [7:0] model_pm();
    return {2'(m_pm[3]), 2'(m_pm[2]), 2'(m_pm[1]), 2'(m_pm[0])};
  endfunction

  // Inputs change just after a falling edge; outputs are read on the next falling edge.
  task automatic set_in(input logic v, input logic [1:0] d);
    i_valid = v;
    i_data  = d;
    #1;
  endtask

  task automatic tick();
    model_step(i_valid, i_data);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pm"},    {o_PM_3, o_PM_2, o_PM_1, o_PM_0}, model_pm());
    check({tag, "_dec"},   o_dec,   m_dec);
    check({tag, "_valid"}, o_valid, m_valid);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_hold_pm", {o_PM_3, o_PM_2, o_PM_1, o_PM_0}, {2'd3, 2'd3, 2'd3, 2'd0});
    rst_n = 1'b1;

    // 1: idle after reset
    set_in(1'b0, 2'b00);
    tick();
    tick();
    check("idle_pm",    {o_PM_3, o_PM_2, o_PM_1, o_PM_0}, {2'd3, 2'd3, 2'd3, 2'd0});
    check("idle_dec",   o_dec,   4'b0000);
    check("idle_valid", o_valid, 1'b0);

    // 2: symbol 00
    set_in(1'b1, 2'b00);
    check("bm_00", {o_BM_3, o_BM_2, o_BM_1, o_BM_0}, {2'd2, 2'd1, 2'd1, 2'd0});
    tick();
    check("s00_pm",    {o_PM_3, o_PM_2, o_PM_1, o_PM_0}, {2'd3, 2'd2, 2'd3, 2'd0});
    check("s00_dec",   o_dec,   4'b0000);
    check("s00_valid", o_valid, 1'b1);

    // 3: symbol 01, ties and saturation in states 1 and 3
    set_in(1'b1, 2'b01);
    check("bm_01", {o_BM_3, o_BM_2, o_BM_1, o_BM_0}, {2'd1, 2'd2, 2'd0, 2'd1});
    tick();
`ifdef VITERBI_PM_NORM_EN
    check("s01_pm", {o_PM_3, o_PM_2, o_PM_1, o_PM_0}, {2'd1, 2'd0, 2'd2, 2'd0});
`else
    check("s01_pm", {o_PM_3, o_PM_2, o_PM_1, o_PM_0}, {2'd2, 2'd1, 2'd3, 2'd1});
`endif
    check("s01_dec", o_dec, 4'b0000);

    // 4: hold with i_valid low
    set_in(1'b0, 2'b11);
    check("bm_11", {o_BM_3, o_BM_2, o_BM_1, o_BM_0}, {2'd0, 2'd1, 2'd1, 2'd2});
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef VITERBI_PM_NORM_EN
      check("hold_pm", {o_PM_3, o_PM_2, o_PM_1, o_PM_0}, {2'd1, 2'd0, 2'd2, 2'd0});
`else
      check("hold_pm", {o_PM_3, o_PM_2, o_PM_1, o_PM_0}, {2'd2, 2'd1, 2'd3, 2'd1});
`endif
      check("hold_dec",   o_dec,   4'b0000);
      check("hold_valid", o_valid, 1'b0);
    end
    check_model("dir_vs_model");

    // 5: random symbols against the model
    for (int i = 0; i < 1000; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
      check("rnd_bm", {o_BM_3, o_BM_2, o_BM_1, o_BM_0}, model_bm(i_data));
      tick();
      check_model("rnd");
    end

    // 6: asynchronous reset between clock edges
    set_in(1'b1, 2'b10);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pm",    {o_PM_3, o_PM_2, o_PM_1, o_PM_0}, {2'd3, 2'd3, 2'd3, 2'd0});
    check("arst_dec",   o_dec,   4'b0000);
    check("arst_valid", o_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 2'($urandom_range(0, 3)));
      tick();
      check_model("post_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
